// File: rtl/tilink_packet_responder.sv
// Calculator-side TI-link packet layer sitting on top of the dbus byte engine.
// Parses MID/CMD/LEN/data/checksum packets from received bytes, streams the
// payload out, and (optionally) answers each data-bearing packet with a
// 4-byte ACK or ERR reply sent back through the dbus transmitter.
module tilink_packet_responder #(
    parameter logic [7:0] c_MACHINEID = 8'h73,
    parameter bit         c_AUTOACK   = 1'b1
) (
    input  logic        i_clock,
    input  logic        i_reset_n,
    input  logic        i_abort,
    input  logic [7:0]  i_rxdata,
    input  logic        i_rxavail,
    output logic        o_rxread,
    output logic [7:0]  o_txdata,
    output logic        o_txenable,
    input  logic        i_txbusy,
    output logic [7:0]  o_mid,
    output logic [7:0]  o_cmd,
    output logic [15:0] o_len,
    output logic [7:0]  o_pdata,
    output logic        o_pvalid,
    output logic        o_done,
    output logic        o_err
);

    localparam logic [7:0] c_CMD_ACK = 8'h56;
    localparam logic [7:0] c_CMD_ERR = 8'h5A;

    typedef enum logic [3:0] {
        ST_HDR_MID,
        ST_HDR_CMD,
        ST_LEN_L,
        ST_LEN_H,
        ST_DATA,
        ST_CS_L,
        ST_CS_H,
        ST_CHECK,
        ST_REPLY0,
        ST_REPLY1,
        ST_REPLY2,
        ST_REPLY3
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [15:0] checksum;
    logic [15:0] remaining;
    logic [7:0]  cs_low;
    logic        cs_good;
    logic [7:0]  reply_cmd;
    logic [7:0]  reply_byte;

    logic        rx_state;
    logic        tx_state;
    logic        rx_take;
    logic        tx_start;
    logic        tx_ack;
    logic        data_cmd;
    logic [15:0] len_rx;

    assign data_cmd = (o_cmd inside {8'h06, 8'h15, 8'h36, 8'h88, 8'hA2, 8'hC9});
    assign len_rx   = {i_rxdata, o_len[7:0]};
    assign rx_take  = rx_state && i_rxavail && !o_rxread && !i_abort;
    assign tx_start = tx_state && !o_txenable && !i_txbusy && !i_abort;
    assign tx_ack   = tx_state && o_txenable && i_txbusy && !i_abort;

    // Classify the current state as receiving or replying and pick the reply byte.
    always_comb begin
        rx_state   = 1'b0;
        tx_state   = 1'b0;
        reply_byte = 8'h00;
        case (state)
            ST_HDR_MID, ST_HDR_CMD, ST_LEN_L, ST_LEN_H,
            ST_DATA, ST_CS_L, ST_CS_H: begin
                rx_state = 1'b1;
            end
            ST_REPLY0: begin
                tx_state   = 1'b1;
                reply_byte = c_MACHINEID;
            end
            ST_REPLY1: begin
                tx_state   = 1'b1;
                reply_byte = reply_cmd;
            end
            ST_REPLY2, ST_REPLY3: begin
                tx_state = 1'b1;
            end
            default: begin
                rx_state = 1'b0;
            end
        endcase
    end

    // Next-state logic: advance once per consumed byte or per accepted reply byte.
    always_comb begin
        state_next = state;
        if (i_abort) begin
            state_next = ST_HDR_MID;
        end else begin
            case (state)
                ST_HDR_MID: if (rx_take) state_next = ST_HDR_CMD;
                ST_HDR_CMD: if (rx_take) state_next = ST_LEN_L;
                ST_LEN_L:   if (rx_take) state_next = ST_LEN_H;
                ST_LEN_H: begin
                    if (rx_take) begin
                        if (!data_cmd) begin
                            state_next = ST_HDR_MID;
                        end else if (len_rx == 16'd0) begin
                            state_next = ST_CS_L;
                        end else begin
                            state_next = ST_DATA;
                        end
                    end
                end
                ST_DATA:   if (rx_take && remaining == 16'd1) state_next = ST_CS_L;
                ST_CS_L:   if (rx_take) state_next = ST_CS_H;
                ST_CS_H:   if (rx_take) state_next = ST_CHECK;
                ST_CHECK:  state_next = c_AUTOACK ? ST_REPLY0 : ST_HDR_MID;
                ST_REPLY0: if (tx_ack) state_next = ST_REPLY1;
                ST_REPLY1: if (tx_ack) state_next = ST_REPLY2;
                ST_REPLY2: if (tx_ack) state_next = ST_REPLY3;
                ST_REPLY3: if (tx_ack) state_next = ST_HDR_MID;
                default:   state_next = ST_HDR_MID;
            endcase
        end
    end

    // State register.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= ST_HDR_MID;
        end else begin
            state <= state_next;
        end
    end

    // Receive side: rx handshake, header capture, payload streaming, checksum and strobes.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_rxread  <= 1'b0;
            o_mid     <= 8'h00;
            o_cmd     <= 8'h00;
            o_len     <= 16'h0000;
            o_pdata   <= 8'h00;
            o_pvalid  <= 1'b0;
            o_done    <= 1'b0;
            o_err     <= 1'b0;
            checksum  <= 16'h0000;
            remaining <= 16'h0000;
            cs_low    <= 8'h00;
            cs_good   <= 1'b0;
            reply_cmd <= 8'h00;
        end else begin
            o_pvalid <= 1'b0;
            o_done   <= 1'b0;
            o_err    <= 1'b0;

            if (i_abort) begin
                o_rxread <= 1'b0;
            end else if (rx_take) begin
                o_rxread <= 1'b1;
            end else if (o_rxread && !i_rxavail) begin
                o_rxread <= 1'b0;
            end

            if (rx_take) begin
                case (state)
                    ST_HDR_MID: o_mid <= i_rxdata;
                    ST_HDR_CMD: o_cmd <= i_rxdata;
                    ST_LEN_L:   o_len[7:0] <= i_rxdata;
                    ST_LEN_H: begin
                        o_len[15:8] <= i_rxdata;
                        if (!data_cmd) begin
                            o_done <= 1'b1;
                        end
                    end
                    ST_DATA: begin
                        o_pdata  <= i_rxdata;
                        o_pvalid <= 1'b1;
                    end
                    ST_CS_L: cs_low <= i_rxdata;
                    ST_CS_H: cs_good <= ({i_rxdata, cs_low} == checksum);
                    default: cs_low <= cs_low;
                endcase
            end

            if (state == ST_CHECK && !i_abort) begin
                o_done    <= cs_good;
                o_err     <= !cs_good;
                reply_cmd <= cs_good ? c_CMD_ACK : c_CMD_ERR;
            end

            if (state_next == ST_HDR_MID) begin
                checksum  <= 16'h0000;
                remaining <= 16'h0000;
            end else if (rx_take && state == ST_LEN_H) begin
                remaining <= len_rx;
            end else if (rx_take && state == ST_DATA) begin
                checksum  <= checksum + {8'h00, i_rxdata};
                remaining <= remaining - 16'd1;
            end
        end
    end

    // Transmit side: offer a reply byte while the dbus is idle, withdraw once it goes busy.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_txenable <= 1'b0;
            o_txdata   <= 8'h00;
        end else if (i_abort) begin
            o_txenable <= 1'b0;
        end else if (tx_start) begin
            o_txenable <= 1'b1;
            o_txdata   <= reply_byte;
        end else if (tx_ack) begin
            o_txenable <= 1'b0;
        end
    end

endmodule
